mc_alu_unit: RTL and testbench

MC_ALU_UNIT -- requirements
Module: mc_alu_unit

---
 rtl/mc_alu_unit.sv | 139 +++++++++++++
 tb/tb_mc_alu_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mc_alu_unit.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/nor/slt plus a WIDTH-cycle
// unsigned shift-add multiply (multu) that returns a double-width product.
module mc_alu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic             addi,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ALUoperation,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         w_dec_op;
    logic               w_dec_err;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_accept, w_last;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

    // addi overrides everything; only ALUop=1x consults func
    always_comb begin
        w_dec_op  = OP_ADD;
        w_dec_err = 1'b0;
        if (!addi && ALUop == 2'b01) begin
            w_dec_op = OP_SUB;
        end else if (!addi && ALUop[1]) begin
            case (func)
                6'b100000: w_dec_op = OP_ADD;
                6'b100010: w_dec_op = OP_SUB;
                6'b100100: w_dec_op = OP_AND;
                6'b100101: w_dec_op = OP_OR;
                6'b100111: w_dec_op = OP_NOR;
                6'b101010: w_dec_op = OP_SLT;
                6'b011001: w_dec_op = OP_MULT;
                default: begin
                    w_dec_op  = OP_BAD;
                    w_dec_err = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_alu_res = '0;
        case (w_dec_op)
            OP_ADD: w_alu_res = a + b;
            OP_SUB: w_alu_res = a - b;
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_NOR: w_alu_res = ~(a | b);
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_alu_res = '0;
        endcase
    end

    // One multiply step: conditionally add multiplicand into the high half,
    // then shift the whole {carry, hi, lo} product right by one.
    assign w_sum  = {1'b0, hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod = {w_sum, result[WIDTH-1:1]};

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (w_dec_op == OP_MULT) ? S_MUL : S_DONE;
            S_MUL:  if (w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUoperation <= '0;
            result       <= '0;
            hi           <= '0;
            zero         <= 1'b0;
            err          <= 1'b0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            ALUoperation <= w_dec_op;
            err          <= w_dec_err;
            hi           <= '0;
            r_cnt        <= '0;
            if (w_dec_op == OP_MULT) begin
                r_mcand  <= a;
                r_mplier <= b;
                result   <= '0;
                zero     <= 1'b0;
            end else begin
                result   <= w_alu_res;
                zero     <= (w_alu_res == '0);
            end
        end else if (r_state == S_MUL) begin
            {hi, result} <= w_prod;
            r_mplier     <= r_mplier >> 1;
            r_cnt        <= r_cnt + 1'b1;
            if (w_last) zero <= (w_prod[WIDTH-1:0] == '0);
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_mc_alu_unit.sv
// Directed bench for mc_alu_unit: single-cycle ops, multu at WIDTH=32 and 8,
// busy-start rejection, back-to-back accept and reset abort of a multiply.
module tb_mc_alu_unit;

    logic        clk = 1'b0;
    logic        reset, start, start8, addi;
    logic [1:0]  ALUop;
    logic [5:0]  func;
    logic [31:0] a, b, res, hi;
    logic [7:0]  a8, b8, res8, hi8;
    logic [3:0]  aop, aop8;
    logic        zero, err, busy, done;
    logic        zero8, err8, busy8, done8;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mc_alu_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .reset(reset), .start(start), .ALUop(ALUop), .addi(addi),
        .func(func), .a(a), .b(b), .ALUoperation(aop), .result(res), .hi(hi),
        .zero(zero), .err(err), .busy(busy), .done(done)
    );

    mc_alu_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUop(ALUop), .addi(addi),
        .func(func), .a(a8), .b(b8), .ALUoperation(aop8), .result(res8), .hi(hi8),
        .zero(zero8), .err(err8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [1:0] aluop, input logic ad,
                      input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] e_op, input logic [31:0] e_res,
                      input logic e_z, input logic e_err);
        @(negedge clk);
        ALUop = aluop; addi = ad; func = fn; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom; func = 6'($urandom);
        @(negedge clk);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".op"},   64'(aop),  64'(e_op));
        chk({tag, ".res"},  64'(res),  64'(e_res));
        chk({tag, ".hi"},   64'(hi),   64'd0);
        chk({tag, ".zero"}, 64'(zero), 64'(e_z));
        chk({tag, ".err"},  64'(err),  64'(e_err));
        @(negedge clk);
        chk({tag, ".done_off"}, 64'(done), 64'd0);
        chk({tag, ".busy_off"}, 64'(busy), 64'd0);
        chk({tag, ".hold"},     64'(res),  64'(e_res));
    endtask

    task automatic mul32(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
        int done_cyc, busy_cyc;
        done_cyc = 0; busy_cyc = 0;
        @(negedge clk);
        ALUop = 2'b10; addi = 1'b0; func = 6'b011001; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (c == 5) begin
                start = 1'b1; ALUop = 2'b00; a = 32'd9; b = 32'd9;
            end
            if (c == 6) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, ".done_cyc"}, 64'(done_cyc), 64'd33);
        chk({tag, ".busy_cyc"}, 64'(busy_cyc), 64'd33);
        chk({tag, ".op"},   64'(aop),  64'h8);
        chk({tag, ".hi"},   64'(hi),   64'(e_hi));
        chk({tag, ".lo"},   64'(res),  64'(e_lo));
        chk({tag, ".zero"}, 64'(zero), 64'd0);
        chk({tag, ".err"},  64'(err),  64'd0);
        @(negedge clk);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        chk({tag, ".hold"}, 64'(res),  64'(e_lo));
    endtask

    initial begin
        int done_cyc, n_done;
        reset = 1'b1; start = 1'b0; start8 = 1'b0; addi = 1'b0;
        ALUop = 2'b00; func = 6'd0; a = '0; b = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.res",  64'(res),  64'd0);
        chk("rst.hi",   64'(hi),   64'd0);
        chk("rst.op",   64'(aop),  64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
        chk("rst.err",  64'(err),  64'd0);
        chk("rst.busy8", 64'(busy8), 64'd0);
        reset = 1'b0;

        op("addi",    2'b01, 1'b1, 6'b100010, 32'd5,        32'd7,        4'b0010, 32'd12,        1'b0, 1'b0);
        op("beq_sub", 2'b01, 1'b0, 6'b000000, 32'h1234,     32'h1234,     4'b0110, 32'd0,         1'b1, 1'b0);
        op("add_wrap",2'b00, 1'b0, 6'b000000, 32'hFFFFFFFF, 32'd1,        4'b0010, 32'd0,         1'b1, 1'b0);
        op("slt",     2'b10, 1'b0, 6'b101010, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1,         1'b0, 1'b0);
        op("slt_f",   2'b11, 1'b0, 6'b101010, 32'd1,        32'hFFFFFFFF, 4'b0111, 32'd0,         1'b1, 1'b0);
        op("nor",     2'b10, 1'b0, 6'b100111, 32'd0,        32'd0,        4'b1100, 32'hFFFFFFFF,  1'b0, 1'b0);
        op("bad",     2'b10, 1'b0, 6'b111111, 32'd3,        32'd4,        4'b1111, 32'd0,         1'b1, 1'b1);
        op("and",     2'b10, 1'b0, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000,  1'b0, 1'b0);
        op("or",      2'b10, 1'b0, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0,  1'b0, 1'b0);
        op("rsub",    2'b10, 1'b0, 6'b100010, 32'd3,        32'd5,        4'b0110, 32'hFFFFFFFE,  1'b0, 1'b0);

        mul32("mul", 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
        op("post_mul_add", 2'b00, 1'b0, 6'b0, 32'd100, 32'd23, 4'b0010, 32'd123, 1'b0, 1'b0);

        // start held high: accepted again once the unit is back in IDLE
        @(negedge clk);
        ALUop = 2'b00; addi = 1'b0; a = 32'd1; b = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b.done1", 64'(done), 64'd1);
        chk("b2b.res1",  64'(res),  64'd3);
        a = 32'd10; b = 32'd20;
        @(negedge clk);
        chk("b2b.gap", 64'(done), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b.done2", 64'(done), 64'd1);
        chk("b2b.res2",  64'(res),  64'd30);
        @(negedge clk);

        // reset during a multiply aborts it
        @(negedge clk);
        ALUop = 2'b10; func = 6'b011001; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort.busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.res",  64'(res),  64'd0);
        chk("abort.hi",   64'(hi),   64'd0);
        chk("abort.op",   64'(aop),  64'd0);
        chk("abort.zero", 64'(zero), 64'd0);
        chk("abort.err",  64'(err),  64'd0);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort.no_done", 64'(n_done), 64'd0);
        op("abort.add", 2'b00, 1'b0, 6'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);

        // WIDTH=8 multiply
        done_cyc = 0;
        @(negedge clk);
        ALUop = 2'b10; addi = 1'b0; func = 6'b011001; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done8) begin
                done_cyc = c;
                break;
            end
        end
        chk("mul8.done_cyc", 64'(done_cyc), 64'd9);
        chk("mul8.hi",  64'(hi8),  64'hFE);
        chk("mul8.lo",  64'(res8), 64'h01);
        chk("mul8.op",  64'(aop8), 64'h8);
        chk("mul8.zero", 64'(zero8), 64'd0);
        @(negedge clk);
        chk("mul8.idle", 64'(busy8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
